// File: rtl/ef_pwm_deadband.sv
// ---------------------------------------------------------------------------
// ef_pwm_deadband
//
// Dead-band / complementary-output stage placed behind one PWM channel. It
// turns a single PWM waveform into a high-side / low-side gate pair with
// independent rising-edge and falling-edge dead times. Both gates are never
// high in the same cycle. Pulses shorter than the dead time are swallowed.
// An external fault latches a shutdown that software must clear.
//
// Ports:
//   clk        block clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   en         stage enable (level)
//   pwm_in     PWM waveform from the PWM core, synchronous to clk
//   rise_dly   rising-edge dead time (both low for rise_dly+1 cycles)
//   fall_dly   falling-edge dead time (both low for fall_dly+1 cycles)
//   fault_in   asynchronous external fault pin, active-high
//   fault_clr  single-cycle pulse that clears a latched fault
//   out_hi     high-side gate drive, registered
//   out_lo     low-side gate drive, registered
//   fault_sts  latched fault status, registered
//   pulse_drop one-cycle pulse when an input pulse is swallowed
// ---------------------------------------------------------------------------
module ef_pwm_deadband #(
  parameter int DBW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           pwm_in,
  input  logic [DBW-1:0] rise_dly,
  input  logic [DBW-1:0] fall_dly,
  input  logic           fault_in,
  input  logic           fault_clr,
  output logic           out_hi,
  output logic           out_lo,
  output logic           fault_sts,
  output logic           pulse_drop
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    LO_ON    = 3'd1,
    DB_R     = 3'd2,
    HI_ON    = 3'd3,
    DB_F     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [DBW-1:0] cnt;
  logic [DBW-1:0] cnt_nxt;
  logic           drop_nxt;
  logic           fault_meta;
  logic           fault_s;

  // Two-flop synchronizer for the asynchronous fault pin. A rising fault_in
  // becomes visible to the next-state logic after two edges, so the state
  // register enters FAULT on the third edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta <= 1'b0;
      fault_s    <= 1'b0;
    end else begin
      fault_meta <= fault_in;
      fault_s    <= fault_meta;
    end
  end

  // Next-state logic. Fault has top priority, then disable, then the normal
  // dead-band sequencing. In the dead-band states pwm_in is examined before
  // the counter so that an input reversal always aborts the pending edge,
  // even on the cycle the count would have expired. The counter is only
  // decremented from a nonzero value, so it can never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drop_nxt  = 1'b0;
    if ((state != FAULT) && fault_s) begin
      state_nxt = FAULT;
    end else if ((state != FAULT) && !en) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED: begin
          if (pwm_in) begin
            state_nxt = DB_R;
            cnt_nxt   = rise_dly;
          end else begin
            state_nxt = DB_F;
            cnt_nxt   = fall_dly;
          end
        end
        LO_ON: begin
          if (pwm_in) begin
            state_nxt = DB_R;
            cnt_nxt   = rise_dly;
          end
        end
        DB_R: begin
          if (!pwm_in) begin
            state_nxt = LO_ON;
            drop_nxt  = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = HI_ON;
          end else begin
            cnt_nxt = cnt - DBW'(1);
          end
        end
        HI_ON: begin
          if (!pwm_in) begin
            state_nxt = DB_F;
            cnt_nxt   = fall_dly;
          end
        end
        DB_F: begin
          if (pwm_in) begin
            state_nxt = HI_ON;
            drop_nxt  = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = LO_ON;
          end else begin
            cnt_nxt = cnt - DBW'(1);
          end
        end
        FAULT: begin
          if (fault_clr && !fault_s) begin
            state_nxt = DISABLED;
          end
        end
        default: begin
          state_nxt = DISABLED;
        end
      endcase
    end
  end

  // State, counter and output registers. Outputs are decoded from the next
  // state so each gate changes on the same edge as the state it reflects,
  // and reset drops both gates immediately without any dead-band wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DISABLED;
      cnt        <= '0;
      out_hi     <= 1'b0;
      out_lo     <= 1'b0;
      fault_sts  <= 1'b0;
      pulse_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_hi     <= (state_nxt == HI_ON);
      out_lo     <= (state_nxt == LO_ON);
      fault_sts  <= (state_nxt == FAULT);
      pulse_drop <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_ef_pwm_deadband.sv
// ---------------------------------------------------------------------------
// tb_ef_pwm_deadband
//
// Directed self-checking bench for ef_pwm_deadband. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point, so
// every check sees the registers settled from the edge just taken. Expected
// output vectors are {out_hi, out_lo, fault_sts, pulse_drop}.
// ---------------------------------------------------------------------------
module tb_ef_pwm_deadband;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pwm_in;
  logic [7:0] rise_dly;
  logic [7:0] fall_dly;
  logic       fault_in;
  logic       fault_clr;
  logic       out_hi;
  logic       out_lo;
  logic       fault_sts;
  logic       pulse_drop;

  int vectors;
  int miscompares;
  int hiCount;
  int loCount;

  ef_pwm_deadband #(.DBW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .rise_dly   (rise_dly),
    .fall_dly   (fall_dly),
    .fault_in   (fault_in),
    .fault_clr  (fault_clr),
    .out_hi     (out_hi),
    .out_lo     (out_lo),
    .fault_sts  (fault_sts),
    .pulse_drop (pulse_drop)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The two gates must never be high together; checked on every falling
  // edge, away from the active edge.
  always @(negedge clk) begin
    assert (!(out_hi && out_lo)) else begin
      miscompares++;
      $error("[TB] FAIL overlap: observed hi=%b lo=%b expected not both 1", out_hi, out_lo);
    end
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive all functional inputs in one step.
  task automatic applyStimulus(input logic e, input logic p, input logic [7:0] rd,
                               input logic [7:0] fd, input logic f, input logic c);
    en        = e;
    pwm_in    = p;
    rise_dly  = rd;
    fall_dly  = fd;
    fault_in  = f;
    fault_clr = c;
  endtask

  // Compare {out_hi, out_lo, fault_sts, pulse_drop} against the expectation.
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {out_hi, out_lo, fault_sts, pulse_drop};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Compare a count of high cycles against the expectation.
  task automatic checkCount(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0);

    // Reset with enable and pwm high: everything held low.
    tick(2);
    checkOutput("reset", 4'b0000);

    // Release; rise_dly=3 gives 4 both-low cycles, then out_hi.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rise_wait", 4'b0000);
    end
    tick();
    checkOutput("first_hi", 4'b1000);

    // Steady PWM, period 20 at 50%, rise_dly=2, fall_dly=5.
    // Per period: out_lo high 10-6=4 cycles, out_hi high 10-3=7 cycles.
    rise_dly = 8'd2;
    fall_dly = 8'd5;
    hiCount  = 0;
    loCount  = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 20; k++) begin
        pwm_in = (k >= 10);
        tick();
        hiCount += int'(out_hi);
        loCount += int'(out_lo);
        if (k < 10) checkOutput("steady_low", {1'b0, (k >= 6), 2'b00});
        else        checkOutput("steady_high", {(k >= 13), 1'b0, 2'b00});
      end
    end
    checkCount("steady_hi_cycles", hiCount, 14);
    checkCount("steady_lo_cycles", loCount, 8);

    // Minimum dead time: zero delays, toggle every 4 cycles.
    rise_dly = 8'd0;
    fall_dly = 8'd0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        pwm_in = (k >= 4);
        tick();
        checkOutput("min_db", {(k >= 5), (k >= 1 && k < 4), 2'b00});
      end
    end

    // Pulse swallow: settle in LO_ON, then a 3-cycle high pulse with rise_dly=4.
    applyStimulus(1'b1, 1'b0, 8'd4, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("swallow_dbf", 4'b0000);
    tick();
    checkOutput("swallow_lo", 4'b0100);
    pwm_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("swallow_dbr", 4'b0000);
    end
    pwm_in = 1'b0;
    tick();
    checkOutput("swallow_drop", 4'b0101);
    tick();
    checkOutput("swallow_after", 4'b0100);

    // Abort on the edge where the count is already zero.
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("abort_dbr0", 4'b0000);
    pwm_in = 1'b0;
    tick();
    checkOutput("abort_drop", 4'b0101);

    // Reach HI_ON with rise_dly=1.
    applyStimulus(1'b1, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("pre_fault_db", 4'b0000);
    tick();
    checkOutput("pre_fault_hi", 4'b1000);

    // Fault mid-HI_ON: FAULT on the third edge after fault_in rises.
    fault_in = 1'b1;
    tick();
    checkOutput("fault_sync1", 4'b1000);
    tick();
    checkOutput("fault_sync2", 4'b1000);
    tick();
    checkOutput("fault_enter", 4'b0010);

    // Clear while fault still present is ignored.
    fault_clr = 1'b1;
    tick();
    checkOutput("fault_clr_ignored", 4'b0010);
    fault_clr = 1'b0;

    // Fault pin drops; status stays latched.
    fault_in = 1'b0;
    tick(3);
    checkOutput("fault_held", 4'b0010);

    // Clear, then full dead time before out_hi.
    fault_clr = 1'b1;
    tick();
    checkOutput("fault_cleared", 4'b0000);
    fault_clr = 1'b0;
    tick(2);
    checkOutput("post_clr_db", 4'b0000);
    tick();
    checkOutput("post_clr_hi", 4'b1000);

    // Fault together with en=0 and fault_clr: the fault wins both.
    fault_in = 1'b1;
    tick(2);
    checkOutput("fault2_sync", 4'b1000);
    en        = 1'b0;
    fault_clr = 1'b1;
    tick();
    checkOutput("fault_vs_disable", 4'b0010);
    tick();
    checkOutput("fault_vs_clr", 4'b0010);
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    tick(2);
    fault_clr = 1'b1;
    tick();
    checkOutput("fault2_cleared", 4'b0000);
    fault_clr = 1'b0;

    // Disable mid-count: rise_dly=6, drop en when cnt reaches 3.
    applyStimulus(1'b1, 1'b1, 8'd6, 8'd2, 1'b0, 1'b0);
    tick(4);
    checkOutput("dis_dbr", 4'b0000);
    en = 1'b0;
    tick();
    checkOutput("dis_off", 4'b0000);

    // Re-enable with pwm low, fall_dly=2: out_lo after three both-low edges.
    en     = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    checkOutput("reen_db", 4'b0000);
    tick();
    checkOutput("reen_lo", 4'b0100);

    // Reset mid-operation drops outputs immediately, no clock needed.
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
